tdc_thermo_encoder: RTL and testbench

Back-end of the TDC fine-time path. Samples the 4·NCARRY4 carry-chain taps of the CARRY4 delay line and bubble-corrects the thermometer code. Converts it to a binary fine count, pairs it with a free-running coarse counter and emits one timestamp per hit. Sits between the delay line and the readout FIFO, one instance per channel.

---
 rtl/tdc_pkg.sv | 18 +
 rtl/tdc_thermo_encoder_if.sv | 15 +
 rtl/tdc_group_popcount.sv | 16 +
 rtl/tdc_thermo_encoder.sv | 172 +++++++++++++++++
 tb/tb_tdc_thermo_encoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types, constants and width helper for the TDC encoder
package tdc_pkg;

  typedef enum logic [1:0] {
    DISARMED,
    WAIT_ZERO,
    ARMED,
    BUSY
  } tdc_state_t;

  localparam int TAPS_PER_CARRY4 = 4;

  // Fine count must represent 0..nt inclusive.
  function automatic int fine_width(input int nt);
    return $clog2(nt + 1);
  endfunction

endpackage

// File: rtl/tdc_thermo_encoder_if.sv
// rtl/tdc_thermo_encoder_if.sv - timestamp output bundle between encoder and readout
interface tdc_thermo_encoder_if #(
  parameter int CW = 16,
  parameter int FW = 6
);

  logic          hit_valid;
  logic [CW-1:0] hit_coarse;
  logic [FW-1:0] hit_fine;
  logic          hit_ovf;

  modport master (output hit_valid, hit_coarse, hit_fine, hit_ovf);
  modport slave  (input  hit_valid, hit_coarse, hit_fine, hit_ovf);

endinterface

// File: rtl/tdc_group_popcount.sv
// rtl/tdc_group_popcount.sv - ones count of the four taps of one CARRY4 cell
module tdc_group_popcount
  import tdc_pkg::*;
(
  input  logic [TAPS_PER_CARRY4-1:0] code,
  output logic [2:0]                 count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < TAPS_PER_CARRY4; i++) begin
      count = count + 3'(code[i]);
    end
  end

endmodule

// File: rtl/tdc_thermo_encoder.sv
// rtl/tdc_thermo_encoder.sv - carry-chain thermometer to timestamp encoder; TDC_BUBBLE_FILTER_EN selects the majority bubble filter
module tdc_thermo_encoder
  import tdc_pkg::*;
#(
  parameter int NCARRY4 = 8,
  parameter int CW      = 16,
  parameter int FW      = fine_width(TAPS_PER_CARRY4 * NCARRY4)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [TAPS_PER_CARRY4*NCARRY4-1:0]    taps,
  output logic                                  armed,
  tdc_thermo_encoder_if.master                  hit
);

  localparam int NT = TAPS_PER_CARRY4 * NCARRY4;

  (* ASYNC_REG = "TRUE" *) logic [NT-1:0] q1;
  (* ASYNC_REG = "TRUE" *) logic [NT-1:0] q2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] c1;
  logic [CW-1:0] c2;

  tdc_state_t    state;
  logic          hit_now;

  logic [NT-1:0] corr;
  logic          a_valid;
  logic [NT-1:0] a_code;
  logic [CW-1:0] a_coarse;

  logic [2:0]    grp   [NCARRY4];
  logic [2:0]    b_cnt [NCARRY4];
  logic          b_valid;
  logic [CW-1:0] b_coarse;
  logic [FW-1:0] sum;

  // Coarse value rides alongside the taps so it stays aligned with q2.
  always_ff @(posedge clk) begin
    if (reset) begin
      q1  <= '0;
      q2  <= '0;
      cnt <= '0;
      c1  <= '0;
      c2  <= '0;
    end else begin
      q1  <= taps;
      q2  <= q1;
      cnt <= cnt + CW'(1);
      c1  <= cnt;
      c2  <= c1;
    end
  end

  assign hit_now = (state == ARMED) && q2[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DISARMED;
      armed <= 1'b0;
    end else if (!enable) begin
      state <= DISARMED;
      armed <= 1'b0;
    end else begin
      case (state)
        DISARMED: begin
          state <= WAIT_ZERO;
          armed <= 1'b0;
        end
        WAIT_ZERO: begin
          if (q2 == '0) begin
            state <= ARMED;
            armed <= 1'b1;
          end else begin
            armed <= 1'b0;
          end
        end
        ARMED: begin
          if (q2[0]) begin
            state <= BUSY;
            armed <= 1'b0;
          end else begin
            armed <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_ZERO;
          armed <= 1'b0;
        end
      endcase
    end
  end

`ifdef TDC_BUBBLE_FILTER_EN
  logic [NT+1:0] ext;

  // Padding: below tap 0 reads as 1, above the last tap reads as 0.
  always_comb begin
    ext  = {1'b0, q2, 1'b1};
    corr = '0;
    for (int i = 0; i < NT; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end
`else
  always_comb begin
    corr = q2;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid  <= 1'b0;
      a_code   <= '0;
      a_coarse <= '0;
    end else begin
      a_valid <= hit_now;
      if (hit_now) begin
        a_code   <= corr;
        a_coarse <= c2;
      end
    end
  end

  for (genvar g = 0; g < NCARRY4; g++) begin : g_pop
    tdc_group_popcount u_pop (
      .code  (a_code[g*TAPS_PER_CARRY4 +: TAPS_PER_CARRY4]),
      .count (grp[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid  <= 1'b0;
      b_coarse <= '0;
      for (int g = 0; g < NCARRY4; g++) begin
        b_cnt[g] <= '0;
      end
    end else begin
      b_valid  <= a_valid;
      b_coarse <= a_coarse;
      for (int g = 0; g < NCARRY4; g++) begin
        b_cnt[g] <= grp[g];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int g = 0; g < NCARRY4; g++) begin
      sum = sum + FW'(b_cnt[g]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit.hit_valid  <= 1'b0;
      hit.hit_coarse <= '0;
      hit.hit_fine   <= '0;
      hit.hit_ovf    <= 1'b0;
    end else begin
      hit.hit_valid <= b_valid;
      if (b_valid) begin
        hit.hit_coarse <= b_coarse;
        hit.hit_fine   <= sum;
        hit.hit_ovf    <= (sum == FW'(NT));
      end
    end
  end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// tb/tb_tdc_thermo_encoder.sv - randomized scoreboard bench for tdc_thermo_encoder
module tb_tdc_thermo_encoder;

  localparam int NCARRY4 = 8;
  localparam int NT      = 32;
  localparam int CW      = 4;
  localparam int FW      = 6;

  localparam int M_OFF  = 0;
  localparam int M_WZ   = 1;
  localparam int M_ARM  = 2;
  localparam int M_BUSY = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [NT-1:0] taps = '0;
  logic          armed;

  always #5 clk = ~clk;

  tdc_thermo_encoder_if #(.CW(CW), .FW(FW)) hit_if ();

  tdc_thermo_encoder #(.NCARRY4(NCARRY4), .CW(CW), .FW(FW)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .taps   (taps),
    .armed  (armed),
    .hit    (hit_if)
  );

  typedef struct {
    int due;
    int coarse;
    int fine;
    int ovf;
  } exp_t;

  exp_t sbq[$];
  bit   exp_armed [int];
  bit   exp_rst   [int];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;

  logic [NT-1:0] mq1 = '0;
  logic [NT-1:0] mq2 = '0;
  int mcnt = 0;
  int mc1 = 0;
  int mc2 = 0;
  int mode = M_OFF;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at edge %0d", nm, got, want, edge_cnt);
    end
  endtask

  // Fine time from the thermometer rule: count taps whose 3-tap vote is majority one.
  function automatic int fine_of(input logic [NT-1:0] v);
    int s = 0;
    for (int i = 0; i < NT; i++) begin
`ifdef TDC_BUBBLE_FILTER_EN
      int below = (i == 0) ? 1 : int'(v[i-1]);
      int above = (i == NT - 1) ? 0 : int'(v[i+1]);
      if (below + int'(v[i]) + above >= 2) s++;
`else
      if (v[i]) s++;
`endif
    end
    return s;
  endfunction

  task automatic model(input int n);
    bit hit;
    int nxt;
    int f;
    if (reset) begin
      mq1 = '0; mq2 = '0; mcnt = 0; mc1 = 0; mc2 = 0; mode = M_OFF;
      sbq.delete();
      exp_rst[n]   = 1'b1;
      exp_armed[n] = 1'b0;
      return;
    end
    hit = (mode == M_ARM) && mq2[0];
    if (hit) begin
      f = fine_of(mq2);
      sbq.push_back('{n + 2, mc2, f, (f == NT) ? 1 : 0});
    end
    if (!enable)              nxt = M_OFF;
    else if (mode == M_OFF)   nxt = M_WZ;
    else if (mode == M_WZ)    nxt = (mq2 == '0) ? M_ARM : M_WZ;
    else if (mode == M_ARM)   nxt = hit ? M_BUSY : M_ARM;
    else                      nxt = M_WZ;
    exp_armed[n] = (nxt == M_ARM);
    mode = nxt;
    mc2  = mc1;
    mc1  = mcnt;
    mcnt = (mcnt + 1) % (1 << CW);
    mq2  = mq1;
    mq1  = taps;
  endtask

  task automatic step(input bit r, input bit e, input logic [NT-1:0] t);
    @(negedge clk);
    reset  = r;
    enable = e;
    taps   = t;
    model(edge_cnt + 1);
  endtask

  function automatic logic [NT-1:0] rand_taps();
    logic [63:0] tmp;
    logic [NT-1:0] v;
    int kind = $urandom_range(0, 6);
    int len  = $urandom_range(1, NT);
    tmp = (64'd1 << len) - 64'd1;
    case (kind)
      0, 1, 2: v = '0;
      3: begin
        v = tmp[NT-1:0];
        repeat ($urandom_range(0, 2)) v[$urandom_range(0, NT - 1)] ^= 1'b1;
      end
      4: v = '1;
      5: v = $urandom();
      default: v = tmp[NT-1:0];
    endcase
    return v;
  endfunction

  int   mon_n;
  bit   synced = 1'b0;
  exp_t mon_e;
  int   hold_c = 0;
  int   hold_f = 0;
  int   hold_o = 0;

  always begin
    @(posedge clk);
    #1;
    mon_n = edge_cnt;
    if (exp_armed.exists(mon_n)) chk("armed", armed, exp_armed[mon_n]);
    if (exp_rst.exists(mon_n)) begin
      synced = 1'b1;
      hold_c = 0; hold_f = 0; hold_o = 0;
      chk("reset_valid", hit_if.hit_valid, 0);
      chk("reset_coarse", hit_if.hit_coarse, 0);
      chk("reset_fine", hit_if.hit_fine, 0);
      chk("reset_ovf", hit_if.hit_ovf, 0);
    end else if (synced) begin
      if (hit_if.hit_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("spurious_strobe", hit_if.hit_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("strobe_edge", mon_n, mon_e.due);
          chk("hit_coarse", hit_if.hit_coarse, mon_e.coarse);
          chk("hit_fine", hit_if.hit_fine, mon_e.fine);
          chk("hit_ovf", hit_if.hit_ovf, mon_e.ovf);
          hold_c = mon_e.coarse; hold_f = mon_e.fine; hold_o = mon_e.ovf;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].due <= mon_n) begin
          chk("missing_strobe", hit_if.hit_valid, 1);
          void'(sbq.pop_front());
        end
        chk("hold_fine", hit_if.hit_fine, hold_f);
        chk("hold_coarse", hit_if.hit_coarse, hold_c);
        chk("hold_ovf", hit_if.hit_ovf, hold_o);
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, '0);

    repeat (3) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 32'h0000_07FF);
    repeat (6) step(1'b0, 1'b1, '0);

    step(1'b0, 1'b1, 32'h0000_0DFF);
    repeat (6) step(1'b0, 1'b1, '0);

    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (6) step(1'b0, 1'b1, '0);

    repeat (10) step(1'b0, 1'b1, 32'h0000_0001);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 32'h0000_003F);
    repeat (6) step(1'b0, 1'b1, '0);

    step(1'b0, 1'b1, 32'h0000_000F);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    repeat (5) step(1'b0, 1'b0, '0);
    repeat (4) step(1'b0, 1'b1, '0);

    step(1'b0, 1'b1, 32'h0000_00FF);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, '0);
    repeat (4) step(1'b0, 1'b1, '0);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) != 0), rand_taps());
    end

    repeat (8) step(1'b0, 1'b1, '0);
    @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
